apb_bridge_mslv: RTL and testbench

APB_BRIDGE_MSLV -- requirements
Module: apb_bridge_mslv

---
 rtl/apb_bridge_mslv.sv | 173 +++++++++++++++++
 tb/tb_apb_bridge_mslv.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bridge_mslv.sv
// ============================================================================
// Module   : apb_bridge_mslv
// Function : AHB-to-APB bridge with address decode onto NUM_SLV APB slaves,
//            error response for unmapped addresses and an optional wait timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb_bridge_mslv #(
    parameter int                    NUM_SLV       = 9,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE      = {32'h40031000, 32'h40021000,
                                                      32'h4001A000, 32'h40017000,
                                                      32'h40018000, 32'h40019000,
                                                      32'h40016000, 32'h40011000,
                                                      32'h40015000},
    parameter int                    SLV_SIZE_LOG2 = 12,
    parameter int                    TIMEOUT       = 0
) (
    input  logic                  hclk,
    input  logic                  hrst,
    input  logic                  harb_apb_hsel,
    input  logic [31:0]           harb_xx_haddr,
    input  logic                  harb_xx_hwrite,
    input  logic [31:0]           harb_xx_hwdata,
    output logic [31:0]           apb_harb_hrdata,
    output logic                  apb_harb_hready,
    output logic [1:0]            apb_harb_hresp,
    output logic [31:0]           apb_xx_paddr,
    output logic                  apb_xx_pwrite,
    output logic [31:0]           apb_xx_pwdata,
    output logic                  apb_xx_penable,
    output logic [NUM_SLV-1:0]    psel_sx,
    input  logic [NUM_SLV*32-1:0] prdata_sx,
    input  logic [NUM_SLV-1:0]    pready_sx,
    input  logic [NUM_SLV-1:0]    pslverr_sx
);

    localparam int         C_TAG_W = 32 - SLV_SIZE_LOG2;
    localparam logic [7:0] C_TMO   = 8'(TIMEOUT);
    localparam logic [1:0] C_OKAY  = 2'b00;
    localparam logic [1:0] C_ERROR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_ERR1   = 3'd4,
        S_ERR2   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic [NUM_SLV-1:0] w_hit_oh;
    logic               w_hit_vld;
    logic [31:0]        w_sel_prdata;
    logic               w_sel_pready;
    logic               w_sel_pslverr;

    // Scan from the top index down so the lowest matching slot overrides.
    always_comb begin
        w_hit_oh      = '0;
        w_hit_vld     = 1'b0;
        w_sel_prdata  = 32'h0;
        w_sel_pready  = 1'b0;
        w_sel_pslverr = 1'b0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (paddr_q[31:SLV_SIZE_LOG2] == SLV_BASE[32*i+SLV_SIZE_LOG2 +: C_TAG_W]) begin
                w_hit_oh      = '0;
                w_hit_oh[i]   = 1'b1;
                w_hit_vld     = 1'b1;
                w_sel_prdata  = prdata_sx[32*i +: 32];
                w_sel_pready  = pready_sx[i];
                w_sel_pslverr = pslverr_sx[i];
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        paddr_d         = paddr_q;
        pwrite_d        = pwrite_q;
        pwdata_d        = pwdata_q;
        wait_cnt_d      = wait_cnt_q;
        psel_sx         = '0;
        apb_xx_penable  = 1'b0;
        apb_harb_hready = 1'b0;
        apb_harb_hresp  = C_OKAY;
        apb_harb_hrdata = 32'h0;

        case (state_q)
            S_IDLE: begin
                apb_harb_hready = 1'b1;
            end
            S_LATCH: begin
                pwdata_d = harb_xx_hwdata;
                state_d  = S_SETUP;
            end
            S_SETUP: begin
                psel_sx    = w_hit_oh;
                wait_cnt_d = 8'h0;
                state_d    = w_hit_vld ? S_ACCESS : S_ERR1;
            end
            S_ACCESS: begin
                psel_sx        = w_hit_oh;
                apb_xx_penable = 1'b1;
                if (w_sel_pready) begin
                    if (w_sel_pslverr) begin
                        state_d = S_ERR1;
                    end else begin
                        apb_harb_hready = 1'b1;
                        if (!pwrite_q) begin
                            apb_harb_hrdata = w_sel_prdata;
                        end
                        state_d = S_IDLE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if ((C_TMO != 8'd0) && (wait_cnt_d == C_TMO)) begin
                        state_d = S_ERR1;
                    end
                end
            end
            S_ERR1: begin
                apb_harb_hresp = C_ERROR;
                state_d        = S_ERR2;
            end
            S_ERR2: begin
                apb_harb_hresp  = C_ERROR;
                apb_harb_hready = 1'b1;
                state_d         = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any state that signals ready can take the next transfer; this
        // overrides the IDLE fall-back chosen above.
        if (apb_harb_hready && harb_apb_hsel) begin
            paddr_d  = harb_xx_haddr;
            pwrite_d = harb_xx_hwrite;
            state_d  = harb_xx_hwrite ? S_LATCH : S_SETUP;
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            state_q    <= S_IDLE;
            paddr_q    <= 32'h0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 32'h0;
            wait_cnt_q <= 8'h0;
        end else begin
            state_q    <= state_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign apb_xx_paddr  = paddr_q;
    assign apb_xx_pwrite = pwrite_q;
    assign apb_xx_pwdata = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_bridge_mslv.sv
// ============================================================================
// Module   : tb_apb_bridge_mslv
// Function : Directed self-checking bench for apb_bridge_mslv (two instances:
//            timeout disabled and TIMEOUT=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb_bridge_mslv;

    localparam int C_NS = 9;

    logic              hclk = 1'b0;
    logic              hrst;
    logic              hsel, hsel_t;
    logic [31:0]       haddr, hwdata;
    logic              hwrite;
    logic [C_NS*32-1:0] prdata;
    logic [C_NS-1:0]   pready, pslverr;

    logic [31:0]       hrdata, paddr, pwdata;
    logic              hready, pwrite, penable;
    logic [1:0]        hresp;
    logic [C_NS-1:0]   psel;

    logic [31:0]       t_hrdata, t_paddr, t_pwdata;
    logic              t_hready, t_pwrite, t_penable;
    logic [1:0]        t_hresp;
    logic [C_NS-1:0]   t_psel;

    int n_chk = 0;
    int n_err = 0;

    always #5 hclk = ~hclk;

    apb_bridge_mslv #(.TIMEOUT(0)) dut (
        .hclk(hclk), .hrst(hrst),
        .harb_apb_hsel(hsel), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
        .harb_xx_hwdata(hwdata),
        .apb_harb_hrdata(hrdata), .apb_harb_hready(hready), .apb_harb_hresp(hresp),
        .apb_xx_paddr(paddr), .apb_xx_pwrite(pwrite), .apb_xx_pwdata(pwdata),
        .apb_xx_penable(penable), .psel_sx(psel),
        .prdata_sx(prdata), .pready_sx(pready), .pslverr_sx(pslverr)
    );

    apb_bridge_mslv #(.TIMEOUT(4)) dut_tmo (
        .hclk(hclk), .hrst(hrst),
        .harb_apb_hsel(hsel_t), .harb_xx_haddr(haddr), .harb_xx_hwrite(hwrite),
        .harb_xx_hwdata(hwdata),
        .apb_harb_hrdata(t_hrdata), .apb_harb_hready(t_hready), .apb_harb_hresp(t_hresp),
        .apb_xx_paddr(t_paddr), .apb_xx_pwrite(t_pwrite), .apb_xx_pwdata(t_pwdata),
        .apb_xx_penable(t_penable), .psel_sx(t_psel),
        .prdata_sx(prdata), .pready_sx(pready), .pslverr_sx(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic samp();
        @(negedge hclk);
    endtask

    initial begin
        hrst = 1'b1; hsel = 1'b0; hsel_t = 1'b0;
        haddr = 32'h0; hwrite = 1'b0; hwdata = 32'h0;
        pready = '1; pslverr = '0;
        for (int i = 0; i < C_NS; i++) prdata[32*i +: 32] = 32'hA5A5_0000 | 32'(i);

        // Reset values
        samp();
        chk("rst_hready", hready, 1);
        chk("rst_hresp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_penable", penable, 0);
        chk("rst_psel", psel, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_t_hready", t_hready, 1);
        hrst = 1'b0;
        tick();

        // Zero-wait read of slot 1
        hsel = 1'b1; haddr = 32'h40011004; hwrite = 1'b0;
        samp(); chk("rd_idle_hready", hready, 1);
        tick(); hsel = 1'b0;
        samp();
        chk("rd_setup_psel", psel, 9'b000000010);
        chk("rd_setup_penable", penable, 0);
        chk("rd_setup_hready", hready, 0);
        chk("rd_setup_paddr", paddr, 32'h40011004);
        tick(); samp();
        chk("rd_acc_penable", penable, 1);
        chk("rd_acc_hready", hready, 1);
        chk("rd_acc_hrdata", hrdata, 32'hA5A5_0001);
        chk("rd_acc_hresp", hresp, 0);
        chk("rd_acc_psel", psel, 9'b000000010);
        tick(); samp();
        chk("rd_idle_psel", psel, 0);
        chk("rd_idle_hrdata", hrdata, 0);

        // Write to slot 8 with three wait cycles
        hsel = 1'b1; haddr = 32'h40031010; hwrite = 1'b1; pready[8] = 1'b0;
        tick(); hsel = 1'b0; hwdata = 32'h1234_5678;
        samp();
        chk("wr_latch_hready", hready, 0);
        chk("wr_latch_psel", psel, 0);
        tick(); hwdata = 32'hDEAD_BEEF;
        samp();
        chk("wr_setup_pwdata", pwdata, 32'h1234_5678);
        chk("wr_setup_psel", psel, 9'h100);
        chk("wr_setup_penable", penable, 0);
        chk("wr_setup_pwrite", pwrite, 1);
        for (int k = 0; k < 3; k++) begin
            tick(); samp();
            chk("wr_wait_hready", hready, 0);
            chk("wr_wait_penable", penable, 1);
            chk("wr_wait_pwdata", pwdata, 32'h1234_5678);
        end
        tick(); pready[8] = 1'b1;
        samp();
        chk("wr_done_hready", hready, 1);
        chk("wr_done_hresp", hresp, 0);
        chk("wr_done_hrdata", hrdata, 0);
        tick(); samp();
        chk("wr_idle_penable", penable, 0);

        // Unmapped read
        hsel = 1'b1; haddr = 32'h50000000; hwrite = 1'b0;
        tick(); hsel = 1'b0;
        samp();
        chk("um_setup_psel", psel, 0);
        chk("um_setup_penable", penable, 0);
        chk("um_setup_hready", hready, 0);
        chk("um_setup_hresp", hresp, 0);
        tick(); samp();
        chk("um_err1_hresp", hresp, 1);
        chk("um_err1_hready", hready, 0);
        chk("um_err1_penable", penable, 0);
        tick(); samp();
        chk("um_err2_hresp", hresp, 1);
        chk("um_err2_hready", hready, 1);
        chk("um_err2_penable", penable, 0);
        tick(); samp();
        chk("um_idle_hresp", hresp, 0);

        // Slave error on slot 3 write, then back-to-back reads from ERR2/ACCESS
        pslverr[3] = 1'b1;
        hsel = 1'b1; haddr = 32'h40019008; hwrite = 1'b1;
        tick(); hsel = 1'b0; hwdata = 32'hCAFE_0003;
        tick(); samp();
        chk("se_setup_psel", psel, 9'h008);
        tick(); samp();
        chk("se_acc_hready", hready, 0);
        chk("se_acc_penable", penable, 1);
        chk("se_acc_hresp", hresp, 0);
        tick(); samp();
        chk("se_err1_hresp", hresp, 1);
        chk("se_err1_hready", hready, 0);
        chk("se_err1_psel", psel, 0);
        tick();
        hsel = 1'b1; haddr = 32'h40015000; hwrite = 1'b0; pslverr[3] = 1'b0;
        samp();
        chk("se_err2_hresp", hresp, 1);
        chk("se_err2_hready", hready, 1);
        tick(); hsel = 1'b0;
        samp();
        chk("b2b_setup_psel", psel, 9'h001);
        chk("b2b_setup_pwrite", pwrite, 0);
        tick(); hsel = 1'b1; haddr = 32'h4001AFFC;
        samp();
        chk("b2b_acc_hready", hready, 1);
        chk("b2b_acc_hrdata", hrdata, 32'hA5A5_0000);
        chk("b2b_acc_hresp", hresp, 0);
        tick(); hsel = 1'b0;
        samp();
        chk("top_setup_psel", psel, 9'h040);
        chk("top_setup_paddr", paddr, 32'h4001AFFC);
        tick(); samp();
        chk("top_acc_hrdata", hrdata, 32'hA5A5_0006);
        tick();

        // Reset pulse during a stalled ACCESS
        pready[5] = 1'b0;
        hsel = 1'b1; haddr = 32'h40017000; hwrite = 1'b0;
        tick(); hsel = 1'b0;
        tick(); samp();
        chk("ra_acc_penable", penable, 1);
        chk("ra_acc_psel", psel, 9'h020);
        #1 hrst = 1'b1;
        #1;
        chk("ra_rst_psel", psel, 0);
        chk("ra_rst_penable", penable, 0);
        chk("ra_rst_hready", hready, 1);
        chk("ra_rst_hresp", hresp, 0);
        chk("ra_rst_paddr", paddr, 0);
        chk("ra_rst_hrdata", hrdata, 0);
        tick(); hrst = 1'b0; pready = '1;
        samp();
        chk("ra_post_psel", psel, 0);
        chk("ra_post_hready", hready, 1);
        hsel = 1'b1; haddr = 32'h40018004; hwrite = 1'b0;
        tick(); hsel = 1'b0;
        samp();
        chk("ra_rd_setup_psel", psel, 9'h010);
        tick(); samp();
        chk("ra_rd_hready", hready, 1);
        chk("ra_rd_hrdata", hrdata, 32'hA5A5_0004);
        tick();

        // Timeout instance: pready held low
        pready = '0;
        hsel_t = 1'b1; haddr = 32'h40015000; hwrite = 1'b0;
        tick(); hsel_t = 1'b0;
        samp();
        chk("to_setup_psel", t_psel, 9'h001);
        for (int k = 0; k < 4; k++) begin
            tick(); samp();
            chk("to_acc_penable", t_penable, 1);
            chk("to_acc_hready", t_hready, 0);
        end
        tick(); samp();
        chk("to_err1_psel", t_psel, 0);
        chk("to_err1_penable", t_penable, 0);
        chk("to_err1_hresp", t_hresp, 1);
        chk("to_err1_hready", t_hready, 0);
        tick(); samp();
        chk("to_err2_hresp", t_hresp, 1);
        chk("to_err2_hready", t_hready, 1);
        tick(); samp();
        chk("to_idle_hresp", t_hresp, 0);
        chk("to_main_idle_psel", psel, 0);
        pready = '1;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
